// File: rtl/frame_pkg.sv
// Shared types and helpers for the I2C frame assembler.
// Holds the assembler FSM state encoding and the header sync-field compare.
// No ports; imported by the assembler top.
package frame_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RECV  = 2'd1,
      CHECK = 2'd2,
      HOLD  = 2'd3
   } state_e;

   localparam logic [7:0] DROP_MAX = 8'hFF;

   // True when the bits above the opcode field equal the sync pattern.
   // The pattern is passed zero-extended to 8 bits.
   function automatic logic sync_match(input logic [7:0] hdr,
                                       input int unsigned opcode_w,
                                       input logic [7:0] pattern);
      logic [7:0] field;
      field = hdr >> opcode_w;
      return field == pattern;
   endfunction

endpackage

// File: rtl/byte_flag_sync.sv
// Brings the I2C slave's byte_flag level into the clk domain and turns each
// rising edge into a single-cycle pulse (3 clk from input rise to pulse).
// Ports: clk, rst (async, active-high), async_in (raw level), rise_pulse (out).
module byte_flag_sync (
   input  logic clk,
   input  logic rst,
   input  logic async_in,
   output logic rise_pulse
);

   logic meta_q;
   logic sync_q;
   logic prev_q;
   logic rise_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         meta_q <= 1'b0;
         sync_q <= 1'b0;
         prev_q <= 1'b0;
         rise_q <= 1'b0;
      end else begin
         meta_q <= async_in;
         sync_q <= meta_q;
         prev_q <= sync_q;
         // Registered edge so a long high level produces exactly one pulse.
         rise_q <= sync_q & ~prev_q;
      end
   end

   assign rise_pulse = rise_q;

endmodule

// File: rtl/i2c_frame_assembler.sv
// Assembles a sync/opcode header plus NUM_OPERANDS big-endian operands from the
// I2C slave byte stream into one payload, offered on frame_valid/frame_ready.
// Ports: clk, rst, byte_flag/byte_data (in), frame_valid/opcode/payload (out),
// frame_ready (in), err_timeout/err_checksum pulses, drop_count (saturating).
// Optional feature macro: FRAME_CHECKSUM_EN adds a trailing XOR checksum byte.
module i2c_frame_assembler
   import frame_pkg::*;
#(
   parameter int                    OPERAND_W      = 32,
   parameter int                    NUM_OPERANDS   = 3,
   parameter int                    OPCODE_W       = 2,
   parameter logic [7-OPCODE_W:0]   SYNC_PATTERN   = 6'b111111,
   parameter int                    TIMEOUT_CYCLES = 1000000
) (
   input  logic                              clk,
   input  logic                              rst,
   input  logic                              byte_flag,
   input  logic [7:0]                        byte_data,
   output logic                              frame_valid,
   input  logic                              frame_ready,
   output logic [OPCODE_W-1:0]               frame_opcode,
   output logic [NUM_OPERANDS*OPERAND_W-1:0] frame_payload,
   output logic                              err_timeout,
   output logic                              err_checksum,
   output logic [7:0]                        drop_count
);

   localparam int PW  = NUM_OPERANDS * OPERAND_W;
   localparam int PB  = PW / 8;
   localparam int BCW = $clog2(PB + 1);
   localparam int TCW = $clog2(TIMEOUT_CYCLES + 1);

   if ((OPERAND_W % 8) != 0 || NUM_OPERANDS < 1 || OPCODE_W < 1 || OPCODE_W > 7
       || TIMEOUT_CYCLES < 1) begin : g_param_check
      $error("i2c_frame_assembler: illegal parameter combination");
   end

   logic capture;

   byte_flag_sync u_sync (
      .clk        (clk),
      .rst        (rst),
      .async_in   (byte_flag),
      .rise_pulse (capture)
   );

   state_e                state_q,   state_d;
   logic [OPCODE_W-1:0]   opcode_q,  opcode_d;
   logic [PW-1:0]         payload_q, payload_d;
   logic [BCW-1:0]        bcnt_q,    bcnt_d;
   logic [TCW-1:0]        tcnt_q,    tcnt_d;
   logic [7:0]            drop_q,    drop_d;
   logic                  err_tmo_q, err_tmo_d;
   logic                  hdr_hit;
   logic                  last_byte;
   logic                  tmo_hit;

   assign hdr_hit   = sync_match(byte_data, OPCODE_W, 8'(SYNC_PATTERN));
   assign last_byte = (bcnt_q == BCW'(PB - 1));
   assign tmo_hit   = (tcnt_q == TCW'(TIMEOUT_CYCLES - 1));

`ifdef FRAME_CHECKSUM_EN
   logic [7:0] csum_q, csum_d;
   logic       err_cs_q, err_cs_d;
`endif

   always_comb begin
      state_d   = state_q;
      opcode_d  = opcode_q;
      payload_d = payload_q;
      bcnt_d    = bcnt_q;
      tcnt_d    = tcnt_q;
      drop_d    = drop_q;
      err_tmo_d = 1'b0;
`ifdef FRAME_CHECKSUM_EN
      csum_d    = csum_q;
      err_cs_d  = 1'b0;
`endif

      case (state_q)
         IDLE: begin
            tcnt_d = '0;
            if (capture && hdr_hit) begin
               opcode_d = byte_data[OPCODE_W-1:0];
               bcnt_d   = '0;
`ifdef FRAME_CHECKSUM_EN
               csum_d   = byte_data;
`endif
               state_d  = RECV;
            end
         end

         RECV: begin
            if (capture) begin
               // Shift left so the first operand byte ends up in the MSBs.
               payload_d = (payload_q << 8) | PW'(byte_data);
               tcnt_d    = '0;
`ifdef FRAME_CHECKSUM_EN
               csum_d    = csum_q ^ byte_data;
`endif
               if (last_byte) begin
`ifdef FRAME_CHECKSUM_EN
                  state_d = CHECK;
`else
                  state_d = HOLD;
`endif
               end else begin
                  bcnt_d = bcnt_q + BCW'(1);
               end
            end else if (tmo_hit) begin
               err_tmo_d = 1'b1;
               tcnt_d    = '0;
               state_d   = IDLE;
            end else begin
               tcnt_d = tcnt_q + TCW'(1);
            end
         end

`ifdef FRAME_CHECKSUM_EN
         CHECK: begin
            if (capture) begin
               tcnt_d = '0;
               if (byte_data == csum_q) begin
                  state_d = HOLD;
               end else begin
                  err_cs_d = 1'b1;
                  state_d  = IDLE;
               end
            end else if (tmo_hit) begin
               err_tmo_d = 1'b1;
               tcnt_d    = '0;
               state_d   = IDLE;
            end else begin
               tcnt_d = tcnt_q + TCW'(1);
            end
         end
`endif

         HOLD: begin
            tcnt_d = '0;
            // Bytes arriving while a frame is held, transfer cycle included,
            // are lost; count them so the consumer can see it fell behind.
            if (capture && (drop_q != DROP_MAX)) begin
               drop_d = drop_q + 8'd1;
            end
            if (frame_ready) begin
               state_d = IDLE;
            end
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= IDLE;
         opcode_q  <= '0;
         payload_q <= '0;
         bcnt_q    <= '0;
         tcnt_q    <= '0;
         drop_q    <= '0;
         err_tmo_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         opcode_q  <= opcode_d;
         payload_q <= payload_d;
         bcnt_q    <= bcnt_d;
         tcnt_q    <= tcnt_d;
         drop_q    <= drop_d;
         err_tmo_q <= err_tmo_d;
      end
   end

`ifdef FRAME_CHECKSUM_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         csum_q   <= '0;
         err_cs_q <= 1'b0;
      end else begin
         csum_q   <= csum_d;
         err_cs_q <= err_cs_d;
      end
   end
   assign err_checksum = err_cs_q;
`else
   assign err_checksum = 1'b0;
`endif

   assign frame_valid   = (state_q == HOLD);
   assign frame_opcode  = opcode_q;
   assign frame_payload = payload_q;
   assign err_timeout   = err_tmo_q;
   assign drop_count    = drop_q;

endmodule

// File: tb/tb_i2c_frame_assembler.sv
// Self-checking bench for i2c_frame_assembler (TIMEOUT_CYCLES=100).
// Directed scenarios plus randomized frames against a stream-level model.
// Build with FRAME_CHECKSUM_EN defined to exercise the checksum variant.
module tb_i2c_frame_assembler;

   localparam int OW  = 32;
   localparam int NO  = 3;
   localparam int OPW = 2;
   localparam int PW  = OW * NO;
   localparam int PB  = PW / 8;
   localparam int TO  = 100;
   localparam logic [5:0] SYNC = 6'b111111;

   typedef logic [7:0] bq_t[$];

   logic            clk = 1'b0;
   logic            rst;
   logic            byte_flag;
   logic [7:0]      byte_data;
   logic            frame_valid;
   logic            frame_ready;
   logic [OPW-1:0]  frame_opcode;
   logic [PW-1:0]   frame_payload;
   logic            err_timeout;
   logic            err_checksum;
   logic [7:0]      drop_count;

   int n_cmp = 0;
   int n_bad = 0;

   logic [OPW-1:0] got_op[$];
   logic [PW-1:0]  got_pl[$];
   int             n_tmo = 0;
   int             n_cse = 0;

   i2c_frame_assembler #(
      .OPERAND_W      (OW),
      .NUM_OPERANDS   (NO),
      .OPCODE_W       (OPW),
      .SYNC_PATTERN   (SYNC),
      .TIMEOUT_CYCLES (TO)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .byte_flag     (byte_flag),
      .byte_data     (byte_data),
      .frame_valid   (frame_valid),
      .frame_ready   (frame_ready),
      .frame_opcode  (frame_opcode),
      .frame_payload (frame_payload),
      .err_timeout   (err_timeout),
      .err_checksum  (err_checksum),
      .drop_count    (drop_count)
   );

   always #5 clk = ~clk;

   // Record transfers and error pulse cycles, sampled mid-cycle.
   always @(negedge clk) begin
      if (!rst) begin
         if (frame_valid && frame_ready) begin
            got_op.push_back(frame_opcode);
            got_pl.push_back(frame_payload);
         end
         if (err_timeout)  n_tmo++;
         if (err_checksum) n_cse++;
      end
   end

   // ---------------- reference model ----------------
   function automatic logic [7:0] xor_of(input bq_t s);
      logic [7:0] x = 8'h00;
      foreach (s[i]) x ^= s[i];
      return x;
   endfunction

   // Header byte, payload bytes, then the checksum byte when enabled.
   function automatic bq_t build_frame(input logic [OPW-1:0] op, input bq_t pl, input bit bad_cs);
      bq_t s;
      s.push_back({SYNC, op});
      foreach (pl[i]) s.push_back(pl[i]);
`ifdef FRAME_CHECKSUM_EN
      s.push_back(xor_of(s) ^ (bad_cs ? 8'h01 : 8'h00));
`else
      if (bad_cs) s.push_back(8'h00);
`endif
      return s;
   endfunction

   // Stream-level view: the first byte whose top bits equal SYNC opens the
   // frame; the next PB bytes are the operands, first byte most significant.
   function automatic void model_frame(input bq_t s, output logic [OPW-1:0] op,
                                       output logic [PW-1:0] pl, output bit found);
      int start = -1;
      found = 0; op = '0; pl = '0;
      for (int i = 0; i < s.size(); i++)
         if (start < 0 && (s[i] >> OPW) == 8'(SYNC)) start = i;
      if (start < 0 || start + PB >= s.size() + 0 && start + PB > s.size() - 1 + 0 && start + PB > s.size() - 1) begin
         if (start < 0 || start + PB > s.size() - 1) return;
      end
      op = s[start][OPW-1:0];
      for (int k = 1; k <= PB; k++) pl = (pl << 8) | PW'(s[start + k]);
`ifdef FRAME_CHECKSUM_EN
      if (start + PB + 1 > s.size() - 1) return;
      begin
         bq_t fr;
         for (int k = 0; k <= PB; k++) fr.push_back(s[start + k]);
         if (xor_of(fr) != s[start + PB + 1]) return;
      end
`endif
      found = 1;
   endfunction

   // ---------------- drivers ----------------
   task automatic send_byte(input logic [7:0] b, input int hold);
      @(posedge clk); #1;
      byte_data = b;
      byte_flag = 1'b1;
      repeat (hold) @(posedge clk);
      #1 byte_flag = 1'b0;
      repeat (4) @(posedge clk);
   endtask

   task automatic send_stream(input bq_t s, input int last_hold);
      foreach (s[i]) send_byte(s[i], (i == s.size() - 1) ? last_hold : 5);
   endtask

   function automatic bq_t rand_payload();
      bq_t p;
      for (int i = 0; i < PB; i++) p.push_back(8'($urandom));
      return p;
   endfunction

   function automatic bq_t spec_payload();
      bq_t p;
      logic [PW-1:0] v = 96'h40000000_40000000_40800000;
      for (int i = PB - 1; i >= 0; i--) p.push_back(v[i*8 +: 8]);
      return p;
   endfunction

   // ---------------- scenarios ----------------
   task automatic test_reset();
      if (frame_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid got %b exp 0", frame_valid); end
      n_cmp++;
      if (frame_opcode !== '0) begin n_bad++; $display("FAIL reset_opcode got %h exp 0", frame_opcode); end
      n_cmp++;
      if (frame_payload !== '0) begin n_bad++; $display("FAIL reset_payload got %h exp 0", frame_payload); end
      n_cmp++;
      if (err_timeout !== 1'b0 || err_checksum !== 1'b0) begin
         n_bad++; $display("FAIL reset_err got %b%b exp 00", err_timeout, err_checksum);
      end
      n_cmp++;
      if (drop_count !== 8'd0) begin n_bad++; $display("FAIL reset_drop got %0d exp 0", drop_count); end
      n_cmp++;
   endtask

   task automatic test_basic();
      bq_t s = build_frame(2'b10, spec_payload(), 0);
      logic [7:0] last = s[s.size() - 1];
      int base = got_op.size();
      s.pop_back();
      send_stream(s, 5);
      @(posedge clk); #1;
      byte_data = last;
      byte_flag = 1'b1;
      repeat (4) @(negedge clk);
      if (frame_valid !== 1'b0) begin n_bad++; $display("FAIL basic_latency_early got %b exp 0", frame_valid); end
      n_cmp++;
      @(negedge clk);
      if (frame_valid !== 1'b1) begin n_bad++; $display("FAIL basic_latency_rise got %b exp 1", frame_valid); end
      n_cmp++;
      @(posedge clk); #1 byte_flag = 1'b0;
      repeat (4) @(posedge clk);
      if (got_op.size() != base + 1) begin
         n_bad++; $display("FAIL basic_count got %0d exp %0d", got_op.size(), base + 1);
      end else if (got_op[base] !== 2'b10 || got_pl[base] !== 96'h40000000_40000000_40800000) begin
         n_bad++; $display("FAIL basic_frame got %h/%h exp 2/40000000_40000000_40800000", got_op[base], got_pl[base]);
      end
      n_cmp++;
   endtask

   task automatic test_garbage_then_frame();
      bq_t pl = rand_payload();
      bq_t s = build_frame(2'b01, pl, 0);
      logic [OPW-1:0] eop; logic [PW-1:0] epl; bit found;
      int base = got_op.size(); int t0 = n_tmo; int c0 = n_cse;
      s.push_front(8'h12);
      model_frame(s, eop, epl, found);
      send_stream(s, 5);
      repeat (3) @(posedge clk);
      if (got_op.size() != base + 1 || !found) begin
         n_bad++; $display("FAIL garbage_count got %0d exp %0d", got_op.size(), base + 1);
      end else if (got_op[base] !== eop || got_pl[base] !== epl) begin
         n_bad++; $display("FAIL garbage_frame got %h/%h exp %h/%h", got_op[base], got_pl[base], eop, epl);
      end
      n_cmp++;
      if (n_tmo != t0 || n_cse != c0) begin
         n_bad++; $display("FAIL garbage_err got %0d/%0d exp 0/0", n_tmo - t0, n_cse - c0);
      end
      n_cmp++;
   endtask

   task automatic test_timeout();
      int base = got_op.size(); int t0 = n_tmo;
      bq_t pl;
      send_byte(8'hFD, 5);
      for (int i = 0; i < 3; i++) send_byte(8'($urandom), 5);
      repeat (150) @(posedge clk);
      if (n_tmo - t0 != 1) begin n_bad++; $display("FAIL timeout_pulse got %0d exp 1", n_tmo - t0); end
      n_cmp++;
      if (got_op.size() != base || frame_valid !== 1'b0) begin
         n_bad++; $display("FAIL timeout_noframe got %0d/%b exp %0d/0", got_op.size(), frame_valid, base);
      end
      n_cmp++;
      pl = rand_payload();
      send_stream(build_frame(2'b11, pl, 0), 5);
      repeat (3) @(posedge clk);
      begin
         logic [OPW-1:0] eop; logic [PW-1:0] epl; bit found;
         model_frame(build_frame(2'b11, pl, 0), eop, epl, found);
         if (got_op.size() != base + 1 || got_pl[got_pl.size() - 1] !== epl) begin
            n_bad++; $display("FAIL timeout_recover got %0d frames exp %0d payload %h", got_op.size(), base + 1, epl);
         end
         n_cmp++;
      end
   endtask

   task automatic test_hold_drop();
      bq_t pl = rand_payload();
      logic [OPW-1:0] eop; logic [PW-1:0] epl; bit found;
      int base = got_op.size();
      model_frame(build_frame(2'b00, pl, 0), eop, epl, found);
      frame_ready = 1'b0;
      send_stream(build_frame(2'b00, pl, 0), 5);
      for (int i = 0; i < 3; i++) send_byte({SYNC, 2'b11}, 5);
      @(negedge clk);
      if (frame_valid !== 1'b1 || frame_payload !== epl || frame_opcode !== eop) begin
         n_bad++; $display("FAIL hold_stable got %b/%h/%h exp 1/%h/%h", frame_valid, frame_opcode, frame_payload, eop, epl);
      end
      n_cmp++;
      if (drop_count !== 8'd3) begin n_bad++; $display("FAIL hold_drop got %0d exp 3", drop_count); end
      n_cmp++;
      @(posedge clk); #1 frame_ready = 1'b1;
      repeat (3) @(negedge clk);
      if (got_op.size() != base + 1 || frame_valid !== 1'b0) begin
         n_bad++; $display("FAIL hold_xfer got %0d/%b exp %0d/0", got_op.size(), frame_valid, base + 1);
      end
      n_cmp++;
   endtask

`ifdef FRAME_CHECKSUM_EN
   task automatic test_checksum();
      int base = got_op.size(); int c0 = n_cse;
      send_stream(build_frame(2'b10, spec_payload(), 1), 5);
      repeat (3) @(posedge clk);
      if (n_cse - c0 != 1) begin n_bad++; $display("FAIL csum_pulse got %0d exp 1", n_cse - c0); end
      n_cmp++;
      if (got_op.size() != base || frame_valid !== 1'b0) begin
         n_bad++; $display("FAIL csum_noframe got %0d exp %0d", got_op.size(), base);
      end
      n_cmp++;
   endtask
`endif

   task automatic test_rst_midframe();
      bq_t s = build_frame(2'b10, rand_payload(), 0);
      bq_t pl = rand_payload();
      logic [OPW-1:0] eop; logic [PW-1:0] epl; bit found;
      for (int i = 0; i < 6; i++) send_byte(s[i], 5);
      @(posedge clk); #3 rst = 1'b1;
      #1;
      if (frame_valid !== 1'b0 || frame_opcode !== '0 || frame_payload !== '0 || drop_count !== 8'd0) begin
         n_bad++; $display("FAIL rst_mid got %b/%h/%h/%0d exp 0/0/0/0", frame_valid, frame_opcode, frame_payload, drop_count);
      end
      n_cmp++;
      repeat (3) @(posedge clk); #1 rst = 1'b0;
      model_frame(build_frame(2'b01, pl, 0), eop, epl, found);
      frame_ready = 1'b0;
      send_stream(build_frame(2'b01, pl, 0), 1000);
      @(negedge clk);
      if (frame_valid !== 1'b1 || frame_payload !== epl || frame_opcode !== eop) begin
         n_bad++; $display("FAIL rst_fresh got %b/%h/%h exp 1/%h/%h", frame_valid, frame_opcode, frame_payload, eop, epl);
      end
      n_cmp++;
      if (drop_count !== 8'd0) begin n_bad++; $display("FAIL rst_longflag got drop %0d exp 0", drop_count); end
      n_cmp++;
      @(posedge clk); #1 frame_ready = 1'b1;
      repeat (3) @(posedge clk);
   endtask

   task automatic test_random();
      for (int f = 0; f < 16; f++) begin
         bq_t s;
         bq_t pl = rand_payload();
         logic [OPW-1:0] op = OPW'($urandom);
         logic [OPW-1:0] eop; logic [PW-1:0] epl; bit found;
         int base = got_op.size();
         int ng = $urandom_range(0, 2);
         s = build_frame(op, pl, 0);
         for (int g = 0; g < ng; g++) begin
            logic [7:0] b = 8'($urandom);
            if ((b >> OPW) == 8'(SYNC)) b[7] = 1'b0;
            s.push_front(b);
         end
         model_frame(s, eop, epl, found);
         frame_ready = ($urandom_range(0, 1) == 1);
         send_stream(s, 5);
         repeat ($urandom_range(0, 20)) @(posedge clk);
         #1 frame_ready = 1'b1;
         repeat (3) @(posedge clk);
         if (!found || got_op.size() != base + 1) begin
            n_bad++; $display("FAIL rand%0d_count got %0d exp %0d", f, got_op.size(), base + 1);
         end else if (got_op[base] !== eop || got_pl[base] !== epl) begin
            n_bad++; $display("FAIL rand%0d_frame got %h/%h exp %h/%h", f, got_op[base], got_pl[base], eop, epl);
         end
         n_cmp++;
      end
      if (drop_count !== 8'd0) begin n_bad++; $display("FAIL rand_drop got %0d exp 0", drop_count); end
      n_cmp++;
   endtask

   initial begin
      rst = 1'b1;
      byte_flag = 1'b0;
      byte_data = 8'h00;
      frame_ready = 1'b1;
      repeat (4) @(posedge clk);
      #1;
      test_reset();
      rst = 1'b0;
      repeat (2) @(posedge clk);
      test_basic();
      test_garbage_then_frame();
      test_timeout();
      test_hold_drop();
`ifdef FRAME_CHECKSUM_EN
      test_checksum();
`endif
      test_rst_midframe();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/i2c_frame_assembler.md
# i2c_frame_assembler

Parametrised frame assembler between the I2C slave byte interface and the datapath/display logic. It detects a sync/opcode header byte and collects a fixed number of big-endian operand bytes into one wide payload. The completed frame is presented on a valid/ready handshake, with inter-byte timeout, optional checksum, and overrun counting. It generalises the earlier fixed 13-byte, three-operand receiver to any operand width and count.

## Interface
- OPERAND_W, 32, operand width in bits; must be a multiple of 8
- NUM_OPERANDS, 3, operands per frame (≥1)
- OPCODE_W, 2, opcode bits in header byte [OPCODE_W-1:0]
- SYNC_PATTERN, 6'b111111, required value of header [7:OPCODE_W] (width 8-OPCODE_W)
- TIMEOUT_CYCLES, 1000000, max clk cycles between consecutive captured bytes of one frame
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-high
- byte_flag  in  1  new-byte level from I2C slave; asynchronous to clk
- byte_data  in  8  received byte; stable while byte_flag high
- frame_valid  out  1  frame available
- frame_ready  in  1  consumer accepts frame
- frame_opcode  out  OPCODE_W  header opcode of held frame
- frame_payload  out  NUM_OPERANDS*OPERAND_W  operand 0 in MSBs, MSB-first byte order
- err_timeout  out  1  one-cycle pulse, frame aborted by timeout
- err_checksum  out  1  one-cycle pulse, checksum mismatch (0 when feature off)
- drop_count  out  8  saturating count of bytes dropped while a frame is held

## Operation
- PAYLOAD_BYTES = NUM_OPERANDS*OPERAND_W/8.
- byte_flag passes through a 2-flop synchroniser and rising-edge detect. Each edge is one capture event that samples byte_data. A high level never yields a second event.
- States: IDLE, RECV, CHECK (checksum builds only), HOLD.
- IDLE: on a capture with byte_data[7:OPCODE_W]==SYNC_PATTERN, latch the opcode, clear the byte counter, and go to RECV. Non-matching bytes are ignored silently.
- RECV: each capture shifts the byte into the payload from the MSB end and increments the counter. At counter==PAYLOAD_BYTES-1 with a capture, go to HOLD, or to CHECK with checksum.
- CHECK: the next capture is compared with the running checksum. A match goes to HOLD. A mismatch pulses err_checksum, discards the frame, and goes to IDLE.
- HOLD: frame_valid=1, and opcode and payload are stable. On frame_valid&&frame_ready, go to IDLE next cycle.
- Capture events in HOLD, including the transfer cycle, are dropped. Each one increments drop_count, saturating at 255.
- Timeout: a cycle counter clears on every capture and counts in RECV/CHECK. On reaching TIMEOUT_CYCLES-1 it pulses err_timeout and returns to IDLE. It is inactive in IDLE/HOLD.
- A sync-pattern byte inside RECV is payload data, not a restart.

## Timing
- Reset values: frame_valid=0, frame_opcode=0, frame_payload=0, err_timeout=0, err_checksum=0, drop_count=0, state=IDLE, synchroniser flops=0.
- Capture latency: byte_flag rise to capture event takes 3 clk (2 sync + edge register).
- frame_valid rises on the clk after the capture of the final byte, which is the last payload byte, or the checksum byte when enabled.
- frame_valid may wait indefinitely for frame_ready. frame_ready while frame_valid=0 is ignored.
- Error pulses last exactly 1 cycle, in the cycle the state returns to IDLE.
- Asynchronous rst mid-frame discards the partial frame immediately. drop_count is cleared only by rst.

## Configuration
- FRAME_CHECKSUM_EN defined: the frame carries a trailing byte equal to the XOR of the header and all payload bytes. The CHECK state exists and err_checksum is functional.
- FRAME_CHECKSUM_EN undefined: no trailing byte and no CHECK state. err_checksum is tied to 0.

## Structure
- Package frame_pkg holds the state enum (IDLE, RECV, CHECK, HOLD) and the function for the header sync-field compare.
- Sub-module byte_flag_sync contains the 2-flop synchroniser and rising-edge pulse generator, with ports clk, rst, async_in, rise_pulse.
- The payload shift register, byte/timeout counters, and FSM stay in the top module.
- Elaboration-time check: OPERAND_W%8==0, NUM_OPERANDS≥1, OPCODE_W in 1..7.

## Test plan
- Default params, frame_ready=1. Send FE, 40 00 00 00, 40 00 00 00, 40 80 00 00 (plus 3E if FRAME_CHECKSUM_EN). Expect frame_valid 1 cycle after the last capture, opcode 2'b10, payload 96'h40000000_40000000_40800000.
- Send 0x12 then a valid frame. 0x12 is ignored, with no error and no frame. The valid frame completes normally.
- TIMEOUT_CYCLES=100. Send FD and 3 bytes, then idle 150 cycles. err_timeout pulses once and frame_valid stays 0. A following full frame is accepted.
- frame_ready=0 after a frame completes. Send 3 more bytes. The frame is held unchanged and drop_count=3. Raise ready: transfer happens and the state returns to IDLE.
- FRAME_CHECKSUM_EN with checksum byte 3F instead of 3E. err_checksum pulses and no frame_valid.
- Assert rst after 6 bytes of a frame. Outputs read reset values. A fresh frame after release is assembled correctly, and a byte_flag held high for 1000 cycles yields one capture only.
